// File: rtl/bcd_arb_pkg.sv
// Shared types and constants for the round-robin binary-to-BCD converter.
package bcd_arb_pkg;
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    localparam int          DIGIT_W     = 4;
    localparam logic [3:0]  BLANK_DIGIT = 4'hF;
endpackage

// File: rtl/bcd_conv_arbiter_div_mod.sv
// Combinational divide/modulo by a constant base; used as the single shared
// divide-by-10 step of the converter.
module div_mod #(
    parameter int BASE  = 10,
    parameter int W_in  = 9,
    parameter int W_mod = 4
) (
    input  logic [W_in-1:0]  i_num,
    output logic [W_in-1:0]  o_quot,
    output logic [W_mod-1:0] o_mod
);
    logic [W_in-1:0] w_rem;

    assign o_quot = i_num / W_in'(BASE);
    assign w_rem  = i_num % W_in'(BASE);
    assign o_mod  = w_rem[W_mod-1:0];
endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one iterative binary-to-BCD converter.
// Optional build macro BCD_ARB_BLANK_EN: leading zero digits read as 4'hF.
module bcd_conv_arbiter
    import bcd_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int W_IN   = 9,
    parameter int DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*W_IN-1:0]     value,
    output logic [N_REQ-1:0]          grant,
    output logic                      busy,
    output logic                      done,
    output logic [DIGITS*DIGIT_W-1:0] digits,
    output logic                      ovf
);
    localparam int PTR_W = (N_REQ  > 1) ? $clog2(N_REQ)  : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t r_state, w_state_nxt;

    logic [PTR_W-1:0]                     r_ptr, r_owner, w_win;
    logic [N_REQ-1:0]                     r_grant;
    logic                                 r_busy, r_done, r_ovf;
    logic [W_IN-1:0]                      r_work, w_quot, w_operand;
    logic [IDX_W-1:0]                     r_idx;
    logic [DIGITS-1:0][DIGIT_W-1:0]       r_dig, w_dig_nxt, w_out, r_digits;
    logic [DIGIT_W-1:0]                   w_rem;
    logic                                 w_last;

    div_mod #(.BASE(10), .W_in(W_IN), .W_mod(DIGIT_W)) u_div (
        .i_num  (r_work),
        .o_quot (w_quot),
        .o_mod  (w_rem)
    );

    // Scan downward so the requester closest above r_ptr wins last.
    always_comb begin
        w_win = '0;
        for (int k = N_REQ-1; k >= 0; k--) begin
            int j;
            j = int'(r_ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (req[j]) w_win = PTR_W'(j);
        end
    end

    assign w_operand = value[w_win*W_IN +: W_IN];
    assign w_last    = (r_idx == IDX_W'(DIGITS-1));

    // Merge this cycle's remainder so the final digit is visible at the DONE load.
    always_comb begin
        w_dig_nxt        = r_dig;
        w_dig_nxt[r_idx] = w_rem;
    end

`ifdef BCD_ARB_BLANK_EN
    always_comb begin
        logic lead;
        lead  = 1'b1;
        w_out = w_dig_nxt;
        for (int k = DIGITS-1; k >= 1; k--) begin
            if (lead && (w_dig_nxt[k] == '0)) begin
                w_out[k] = BLANK_DIGIT;
            end else begin
                lead = 1'b0;
            end
        end
    end
`else
    assign w_out = w_dig_nxt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (|req)  w_state_nxt = CONV;
            CONV:    if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= '0;
            r_owner  <= '0;
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_work   <= '0;
            r_idx    <= '0;
            r_dig    <= '0;
            r_digits <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_grant <= N_REQ'(1) << w_win;
                        r_owner <= w_win;
                        r_busy  <= 1'b1;
                        r_work  <= w_operand;
                        r_idx   <= '0;
                        r_dig   <= '0;
                    end
                end
                CONV: begin
                    r_dig  <= w_dig_nxt;
                    r_work <= w_quot;
                    if (w_last) begin
                        r_digits <= w_out;
                        r_ovf    <= (w_quot != '0);
                        r_done   <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_ptr   <= (r_owner == PTR_W'(N_REQ-1)) ? '0 : r_owner + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign grant  = r_grant;
    assign busy   = r_busy;
    assign done   = r_done;
    assign digits = r_digits;
    assign ovf    = r_ovf;
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench: table-driven conversions on 3- and 2-digit builds, plus
// round-robin, mid-conversion reset and early req-drop sequences.
module tb_bcd_conv_arbiter;
    localparam int N = 4;
    localparam int W = 9;

`ifdef BCD_ARB_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  req, req2;
    logic [N*W-1:0] value, value2;
    logic [N-1:0]  grant, grant2;
    logic          busy, busy2, done, done2, ovf, ovf2;
    logic [11:0]   digits;
    logic [7:0]    digits2;

    int n_chk  = 0;
    int n_pass = 0;

    bcd_conv_arbiter #(.N_REQ(N), .W_IN(W), .DIGITS(3)) dut (
        .clk(clk), .rst(rst), .req(req), .value(value), .grant(grant),
        .busy(busy), .done(done), .digits(digits), .ovf(ovf)
    );

    bcd_conv_arbiter #(.N_REQ(N), .W_IN(W), .DIGITS(2)) dut2 (
        .clk(clk), .rst(rst), .req(req2), .value(value2), .grant(grant2),
        .busy(busy2), .done(done2), .digits(digits2), .ovf(ovf2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        int          val;
        logic [11:0] d_plain;
        logic [11:0] d_blank;
        logic        ovf;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; req2 = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst grant",  32'(grant),  0);
        chk("rst busy",   32'(busy),   0);
        chk("rst done",   32'(done),   0);
        chk("rst digits", 32'(digits), 0);
        chk("rst ovf",    32'(ovf),    0);
        chk("rst digits2", 32'(digits2), 0);
    endtask

    // One full conversion on either build; req is dropped right after grant.
    task automatic run_one(input bit sel, input int idx, input int val,
                           input logic [11:0] exp_d, input logic exp_o);
        int nd;
        nd = sel ? 2 : 3;
        if (sel) begin value2[idx*W +: W] = W'(val); req2 = N'(1) << idx; end
        else     begin value [idx*W +: W] = W'(val); req  = N'(1) << idx; end
        tick();
        chk("grant", sel ? 32'(grant2) : 32'(grant), 32'(1) << idx);
        chk("busy",  sel ? 32'(busy2)  : 32'(busy),  1);
        req = '0; req2 = '0;
        if (sel) value2[idx*W +: W] = '1;
        else     value [idx*W +: W] = '1;
        for (int c = 1; c <= nd; c++) begin
            tick();
            if (c < nd) chk("done early", sel ? 32'(done2) : 32'(done), 0);
        end
        chk("done",   sel ? 32'(done2)   : 32'(done),   1);
        chk("digits", sel ? 32'(digits2) : 32'(digits), 32'(exp_d));
        chk("ovf",    sel ? 32'(ovf2)    : 32'(ovf),    32'(exp_o));
        chk("busy@done", sel ? 32'(busy2) : 32'(busy), 1);
        tick();
        chk("done pulse", sel ? 32'(done2)  : 32'(done),  0);
        chk("grant idle", sel ? 32'(grant2) : 32'(grant), 0);
        chk("busy idle",  sel ? 32'(busy2)  : 32'(busy),  0);
        chk("digits hold", sel ? 32'(digits2) : 32'(digits), 32'(exp_d));
    endtask

    vec_t tab3[8];
    vec_t tab2[4];
    logic [N-1:0] rr_exp[5];

    initial begin
        int n;
        req = '0; req2 = '0; value = '0; value2 = '0;

        tab3[0] = '{0, 357, 12'h357, 12'h357, 1'b0};
        tab3[1] = '{1, 511, 12'h511, 12'h511, 1'b0};
        tab3[2] = '{2,   0, 12'h000, 12'hFF0, 1'b0};
        tab3[3] = '{3,   7, 12'h007, 12'hFF7, 1'b0};
        tab3[4] = '{0,  42, 12'h042, 12'hF42, 1'b0};
        tab3[5] = '{1, 100, 12'h100, 12'h100, 1'b0};
        tab3[6] = '{2, 205, 12'h205, 12'h205, 1'b0};
        tab3[7] = '{3,  10, 12'h010, 12'hF10, 1'b0};

        tab2[0] = '{0, 123, 12'h023, 12'h023, 1'b1};
        tab2[1] = '{1,  99, 12'h099, 12'h099, 1'b0};
        tab2[2] = '{2,   5, 12'h005, 12'h0F5, 1'b0};
        tab2[3] = '{3, 250, 12'h050, 12'h050, 1'b1};

        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

        do_reset();

        for (int i = 0; i < 8; i++)
            run_one(1'b0, tab3[i].idx, tab3[i].val,
                    BLANK ? tab3[i].d_blank : tab3[i].d_plain, tab3[i].ovf);
        for (int i = 0; i < 4; i++)
            run_one(1'b1, tab2[i].idx, tab2[i].val,
                    BLANK ? tab2[i].d_blank : tab2[i].d_plain, tab2[i].ovf);

        // Reset in the second CONV cycle aborts with no done pulse.
        value[0 +: W] = W'(357); req = 4'b0001;
        tick();
        chk("abort grant", 32'(grant), 1);
        tick();
        rst = 1'b1; req = '0;
        tick();
        rst = 1'b0;
        chk("abort grant0",  32'(grant),  0);
        chk("abort busy0",   32'(busy),   0);
        chk("abort digits0", 32'(digits), 0);
        chk("abort done0",   32'(done),   0);
        tick();
        chk("abort no done", 32'(done), 0);
        run_one(1'b0, 2, 5, BLANK ? 12'hFF5 : 12'h005, 1'b0);

        // Round robin with all requesters held.
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (grant == '0 && n < 8) begin tick(); n++; end
            chk("rr grant", 32'(grant), 32'(rr_exp[g]));
            n = 0;
            while (grant != '0 && n < 8) begin tick(); n++; end
            chk("rr release", 32'(n < 8), 1);
        end
        req = '0;
        for (int c = 0; c < 6; c++) tick();

        // req0 dropped one cycle after grant; next search starts at requester 1.
        do_reset();
        value[0 +: W] = W'(86); req = 4'b0001;
        tick();
        chk("drop grant", 32'(grant), 1);
        tick();
        req = '0;
        tick(); tick();
        chk("drop done",   32'(done),   1);
        chk("drop digits", 32'(digits), BLANK ? 32'h0F86 : 32'h0086);
        tick();
        req = 4'b1001;
        tick();
        chk("drop next grant", 32'(grant), 32'b1000);
        req = '0;
        for (int c = 0; c < 6; c++) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
